// File: rtl/ft245_sync_arb_to_axis.sv
// FT245/FT600-style synchronous FIFO bridge to AXI-Stream with a read/write
// arbitration FSM, forced bus turnaround through IDLE, and a read skid FIFO.
module ft245_sync_arb_to_axis #(
    parameter int unsigned bus_width   = 1,
    parameter int unsigned skid_depth  = 4,
    parameter int unsigned burst_max   = 16,
    parameter bit          rx_priority = 1'b1
) (
    input  logic                   ft245_dclk,
    input  logic                   rstn,
    inout  wire  [bus_width-1:0]   ft245_ben,
    inout  wire  [bus_width*8-1:0] ft245_data,
    output logic                   ft245_rdn,
    output logic                   ft245_wrn,
    output logic                   ft245_siwun,
    input  logic                   ft245_txen,
    input  logic                   ft245_rxfn,
    output logic                   ft245_oen,
    output logic                   ft245_rstn,
    output logic                   ft245_wakeupn,
    input  logic [bus_width*8-1:0] s_axis_tdata,
    input  logic [bus_width-1:0]   s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [bus_width*8-1:0] m_axis_tdata,
    output logic [bus_width-1:0]   m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);
    localparam int unsigned DW = bus_width * 8;
    localparam int unsigned EW = DW + bus_width;
    localparam int unsigned PW = $clog2(skid_depth);
    localparam int unsigned BW = $clog2(burst_max + 1);
    localparam logic [PW:0]   DEPTH = (PW+1)'(skid_depth);
    localparam logic [PW:0]   CNT1  = (PW+1)'(1);
    localparam logic [BW-1:0] BURST = BW'(burst_max);

    typedef enum logic [2:0] {IDLE, RD_OE, RD, RD_END, WR} state_t;

    state_t          state;
    logic            last_rd;
    logic [BW-1:0]   burst_cnt;
    logic [BW-1:0]   burst_inc;
    logic [EW-1:0]   mem [skid_depth];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [PW:0]     free;
    logic [PW:0]     free_next;
    logic            push;
    logic            pop;
    logic            rd_req;
    logic            wr_req;
    logic            wr_beat;

    assign ft245_siwun   = 1'b0;
    assign ft245_wakeupn = 1'b0;
    assign ft245_rstn    = rstn;

    // The FPGA owns the bus only in WR; the device drives it while oen is low.
    assign ft245_data = (state == WR) ? s_axis_tdata : {DW{1'bz}};
    assign ft245_ben  = (state == WR) ? s_axis_tkeep : {bus_width{1'bz}};

    assign push      = (state == RD) && !ft245_rxfn;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign free      = DEPTH - count;
    assign free_next = free - (PW+1)'(push) + (PW+1)'(pop);
    assign rd_req    = !ft245_rxfn && (free >= (PW+1)'(2));
    assign wr_req    = !ft245_txen && s_axis_tvalid;
    assign burst_inc = burst_cnt + BW'(1);

    assign s_axis_tready = (state == WR) && !ft245_txen;
    assign wr_beat       = s_axis_tvalid && s_axis_tready;
    assign ft245_wrn     = !wr_beat;

    assign m_axis_tvalid = (count != '0);
    assign {m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];

    always_ff @(posedge ft245_dclk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ft245_rdn <= 1'b1;
            ft245_oen <= 1'b1;
            burst_cnt <= '0;
            last_rd   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (rd_req && (rx_priority || !wr_req || !last_rd)) begin
                        state     <= RD_OE;
                        ft245_oen <= 1'b0;
                    end else if (wr_req) begin
                        state <= WR;
                    end
                end
                RD_OE: begin
                    state     <= RD;
                    ft245_rdn <= 1'b0;
                end
                RD: begin
                    if (push) burst_cnt <= burst_inc;
                    // Exit is decided on the capturing edge, so rdn rises before any further beat.
                    if (ft245_rxfn || (push && burst_inc == BURST) || free_next == '0) begin
                        state     <= RD_END;
                        ft245_rdn <= 1'b1;
                        ft245_oen <= 1'b1;
                    end
                end
                RD_END: begin
                    state   <= IDLE;
                    last_rd <= 1'b1;
                end
                WR: begin
                    if (wr_beat) burst_cnt <= burst_inc;
                    if (ft245_txen || !s_axis_tvalid || (wr_beat && burst_inc == BURST)) begin
                        state   <= IDLE;
                        last_rd <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ft245_dclk or negedge rstn) begin
        if (!rstn) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ft245_ben, ft245_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT1;
                2'b01:   count <= count - CNT1;
                default: count <= count;
            endcase
        end
    end
endmodule
